// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// Entry layout, 2-bit counter encodings and the saturating update rule.
package bp_pkg;

  localparam int unsigned BP_XLEN   = 32;
  // Widest tag, reached at the minimum table size of 2 entries; narrower tags are zero-extended
  localparam int unsigned TAG_MAX_W = BP_XLEN - 3;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [BP_XLEN-1:0]   target;
    logic                 jmp;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    unique case (ctr)
      SNT: res = taken ? WNT : SNT;
      WNT: res = taken ? WT  : SNT;
      WT:  res = taken ? ST  : WNT;
      ST:  res = taken ? ST  : WT;
      default: res = ctr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// Direct-mapped BTB storage: async read port for fetch, async read plus
// synchronous write port for execute, cleared on reset.
module btb_ram
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_f,
  output btb_entry_t       rd_entry_f,
  input  logic [IDX_W-1:0] rd_idx_e,
  output btb_entry_t       rd_entry_e,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry_f = mem_q[rd_idx_f];
  assign rd_entry_e = mem_q[rd_idx_e];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB predictor: combinational lookup on PCF, training and
// mispredict detection on the resolved E-stage control instruction.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = BP_XLEN,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] NPCF,
  output logic            PredTakenF,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
);

  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [XLEN-1:0] pc);
    return TAG_MAX_W'(pc >> (IDX_W + 2));
  endfunction

  logic [IDX_W-1:0] idx_f, idx_e;
  btb_entry_t       ent_f, ent_e, wr_entry;
  logic             wr_en;
  logic             hit_f, hit_e;
  logic             ctl, taken_e, train;
  logic [31:0]      branch_cnt_q, mispred_cnt_q;

  assign idx_f = PCF[IDX_W+1:2];
  assign idx_e = PCE[IDX_W+1:2];

  btb_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_f   (idx_f),
    .rd_entry_f (ent_f),
    .rd_idx_e   (idx_e),
    .rd_entry_e (ent_e),
    .wr_en      (wr_en),
    .wr_idx     (idx_e),
    .wr_entry   (wr_entry)
  );

  // Fetch lookup
  assign hit_f      = ent_f.valid && (ent_f.tag == tag_of(PCF));
  assign PredTakenF = hit_f && (ent_f.jmp || ent_f.ctr[1]);
  assign NPCF       = PredTakenF ? ent_f.target : PCF + XLEN'(4);

  // Execute resolution
  assign ctl         = UpdateE && (BranchE || JumpE || JalrE);
  assign taken_e     = TakenE || JumpE || JalrE;
  assign train       = ctl && (BranchE || JumpE);
  assign hit_e       = ent_e.valid && (ent_e.tag == tag_of(PCE));
  assign MispredictE = ctl && ((taken_e != PredTakenE) ||
                               (taken_e && (TargetE != PredTargetE)));
  assign RedirectPCE = taken_e ? TargetE : PCE + XLEN'(4);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ent_e;
    if (train) begin
      if (!hit_e) begin
        if (taken_e) begin
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = tag_of(PCE);
          wr_entry.target = TargetE;
          wr_entry.jmp    = JumpE;
          wr_entry.ctr    = WT;
        end
      end else begin
        wr_en = 1'b1;
        if (BranchE) wr_entry.ctr    = sat_update(ent_e.ctr, taken_e);
        if (taken_e) wr_entry.target = TargetE;
        if (JumpE)   wr_entry.ctr    = ST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ctl)         branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations
// (16 entries, so 0x100/0x140/0x200 share index 0).
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic [31:0] NPCF;
  logic        PredTakenF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        BranchE, JumpE, JalrE, TakenE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount, MispredictCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  branch_predictor #(
    .XLEN    (32),
    .ENTRIES (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCF             (PCF),
    .NPCF            (NPCF),
    .PredTakenF      (PredTakenF),
    .UpdateE         (UpdateE),
    .PCE             (PCE),
    .BranchE         (BranchE),
    .JumpE           (JumpE),
    .JalrE           (JalrE),
    .TakenE          (TakenE),
    .TargetE         (TargetE),
    .PredTakenE      (PredTakenE),
    .PredTargetE     (PredTargetE),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_e(input logic upd, input logic br, input logic jmp, input logic jalr,
                       input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    UpdateE     = upd;
    BranchE     = br;
    JumpE       = jmp;
    JalrE       = jalr;
    TakenE      = tk;
    PCE         = pce;
    TargetE     = tgt;
    PredTakenE  = ptk;
    PredTargetE = ptgt;
  endtask

  task automatic idle_e();
    set_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic ptk,
                      input logic [31:0] npc);
    PCF = pc;
    #1;
    check({tag, "_ptk"}, 32'(PredTakenF), 32'(ptk));
    check({tag, "_npc"}, NPCF, npc);
  endtask

  task automatic counts(input string tag, input int unsigned bc, input int unsigned mc);
    check({tag, "_bcnt"}, BranchCount, bc);
    check({tag, "_mcnt"}, MispredictCount, mc);
  endtask

  initial begin
    rst_n = 1'b0;
    PCF   = 32'h100;
    idle_e();
    #3;
    look("rst", 32'h100, 1'b0, 32'h104);
    counts("rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Taken branch at 0x100 allocates; same-cycle lookup still sees the miss
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    look("alloc_same", 32'h100, 1'b0, 32'h104);
    check("alloc_mis", 32'(MispredictE), 32'd1);
    check("alloc_redir", RedirectPCE, 32'h80);
    tick();
    idle_e();
    look("alloc_next", 32'h100, 1'b1, 32'h80);
    counts("alloc", 1, 1);

    // Not taken twice: 10 -> 01 (mispredict) -> 00 (correctly predicted)
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    #1;
    check("nt1_mis", 32'(MispredictE), 32'd1);
    check("nt1_redir", RedirectPCE, 32'h104);
    tick();
    idle_e();
    look("nt1_next", 32'h100, 1'b0, 32'h104);
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    check("nt2_mis", 32'(MispredictE), 32'd0);
    tick();
    idle_e();
    look("nt2_next", 32'h100, 1'b0, 32'h104);
    counts("nt", 3, 2);

    // jalr: forced taken, mispredicts, never allocates
    set_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, 1'b0, 32'h204);
    #1;
    check("jalr_mis", 32'(MispredictE), 32'd1);
    check("jalr_redir", RedirectPCE, 32'h40);
    tick();
    idle_e();
    look("jalr_next", 32'h200, 1'b0, 32'h204);
    counts("jalr", 4, 3);

    // Aliasing: 0x100 (ctr 00 -> 01), then 0x140 evicts it at index 0
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    tick();
    idle_e();
    look("alias_weak", 32'h100, 1'b0, 32'h104);
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h140, 32'h300, 1'b0, 32'h144);
    tick();
    idle_e();
    look("alias_new", 32'h140, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    counts("alias", 6, 5);

    // Unconditional jump allocates with jmp set; correctly predicted pick
    set_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h400, 1'b1, 32'h400);
    #1;
    check("jump_mis", 32'(MispredictE), 32'd0);
    check("jump_redir", RedirectPCE, 32'h400);
    tick();
    idle_e();
    look("jump_next", 32'h104, 1'b1, 32'h400);
    counts("jump", 7, 5);

    // Same-cycle lookup/update of 0x140: old prediction now, new one next cycle
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h140, 32'h300, 1'b1, 32'h300);
    look("same_old", 32'h140, 1'b1, 32'h300);
    check("same_mis", 32'(MispredictE), 32'd1);
    tick();
    idle_e();
    look("same_new", 32'h140, 1'b0, 32'h144);
    counts("same", 8, 6);

    // Invalid E instruction: no count, no mispredict; PC+4 wraps
    set_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'h10);
    look("wrap_f", 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("wrap_redir", RedirectPCE, 32'h0);
    check("noupd_mis", 32'(MispredictE), 32'd0);
    tick();
    idle_e();
    counts("noupd", 8, 6);

    // Mid-stream async reset; a ctl pulse during reset is dropped
    look("pre_rst", 32'h104, 1'b1, 32'h400);
    rst_n = 1'b0;
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 32'h500, 1'b0, 32'h10C);
    look("async_rst", 32'h104, 1'b0, 32'h108);
    counts("async_rst", 0, 0);
    tick();
    idle_e();
    rst_n = 1'b1;
    look("drop_ctl", 32'h108, 1'b0, 32'h10C);
    counts("drop_ctl", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
